// File: rtl/frame_fifo_if.sv
// frame_fifo_if -- write/read handshake bundle for frame_fifo.
//
// Write side : wr_en, sof_in, eof_in, err_in, din   (master -> slave)
//              full, almost_full, drop_pulse        (slave -> master)
// Read side  : rd_en                                (master -> slave)
//              dout, sof_out, eof_out, empty,
//              frame_count                          (slave -> master)
//
// DATA_WIDTH and DEPTH must match the frame_fifo instance this bundle
// connects to; frame_count is sized from DEPTH.
interface frame_fifo_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                  wr_en;
    logic                  sof_in;
    logic                  eof_in;
    logic                  err_in;
    logic [DATA_WIDTH-1:0] din;
    logic                  full;
    logic                  almost_full;
    logic                  drop_pulse;

    logic                  rd_en;
    logic [DATA_WIDTH-1:0] dout;
    logic                  sof_out;
    logic                  eof_out;
    logic                  empty;
    logic [CW-1:0]         frame_count;

    // Producer/consumer side (testbench or upstream logic).
    modport master (
        output wr_en, sof_in, eof_in, err_in, din, rd_en,
        input  full, almost_full, drop_pulse,
        input  dout, sof_out, eof_out, empty, frame_count
    );

    // FIFO side.
    modport slave (
        input  wr_en, sof_in, eof_in, err_in, din, rd_en,
        output full, almost_full, drop_pulse,
        output dout, sof_out, eof_out, empty, frame_count
    );
endinterface

// File: rtl/frame_fifo.sv
// frame_fifo -- store-and-forward frame FIFO with error/overflow drop.
//
// Words are written speculatively at wr_ptr; the reader only ever sees
// words below commit_ptr, which advances when a frame's eof word is
// accepted cleanly. A bad frame (err_in, overflow, or a missing eof
// detected by a new sof) is discarded by rewinding wr_ptr to commit_ptr
// and pulsing drop_pulse for one cycle.
//
// Ports:
//   clock  single clock, rising edge
//   reset  synchronous, active-high
//   bus    frame_fifo_if.slave (write strobe + markers + data, read strobe,
//          dout/sof_out/eof_out, empty, full, almost_full, frame_count,
//          drop_pulse)
//
// Parameters:
//   DATA_WIDTH    payload width
//   DEPTH         word capacity, power of two, >= 4
//   AFULL_THRESH  occupancy (including uncommitted words) for almost_full
module frame_fifo #(
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 256,
    parameter int AFULL_THRESH = DEPTH - 16
) (
    input  logic         clock,
    input  logic         reset,
    frame_fifo_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef logic [PW-1:0] ptr_t;

    typedef enum logic [1:0] {
        IDLE,
        IN_FRAME,
        DROP
    } state_t;

    typedef struct packed {
        logic                  sof;
        logic                  eof;
        logic [DATA_WIDTH-1:0] data;
    } word_t;

    state_t state;
    state_t next_state;

    // Pointers carry one extra wrap bit so full and empty are distinct.
    ptr_t wr_ptr;
    ptr_t commit_ptr;
    ptr_t rd_ptr;

    word_t mem [DEPTH];
    word_t rd_word;

    logic [PW-1:0] frame_count;
    logic          drop_pulse;
    logic [DATA_WIDTH-1:0] dout;
    logic          sof_out;
    logic          eof_out;

    // Write-side decode.
    logic start;      // accepted word opens a new frame (from any state)
    logic cont;       // accepted word continues the open frame
    logic restart;    // new sof while a frame was still open
    logic no_room;
    logic reject;
    logic do_write;
    logic do_commit;
    logic do_drop;
    ptr_t base_ptr;
    ptr_t occupancy;
    logic rd_fire;

    // NOTE: every signal driven here gets a default assignment first, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        start      = bus.wr_en && bus.sof_in;
        cont       = bus.wr_en && !bus.sof_in && (state == IN_FRAME);
        restart    = start && (state == IN_FRAME);
        // A new frame always begins at commit_ptr, which also discards any
        // partial frame left open by a missing eof.
        base_ptr   = cont ? wr_ptr : commit_ptr;
        // Room is judged against rd_ptr before this cycle's read: a
        // simultaneous read does not free space for the same write.
        no_room    = (ptr_t'(base_ptr - rd_ptr) == ptr_t'(DEPTH));
        reject     = (start || cont) && (bus.err_in || no_room);
        do_write   = (start || cont) && !reject;
        do_commit  = do_write && bus.eof_in;
        do_drop    = reject || restart;

        next_state = state;
        if (reject) begin
            next_state = bus.eof_in ? IDLE : DROP;
        end else if (do_write) begin
            next_state = bus.eof_in ? IDLE : IN_FRAME;
        end else if (bus.wr_en && bus.eof_in && (state == DROP)) begin
            next_state = IDLE;
        end
    end

    assign rd_word   = mem[rd_ptr[AW-1:0]];
    assign rd_fire   = bus.rd_en && (rd_ptr != commit_ptr);
    assign occupancy = wr_ptr - rd_ptr;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            commit_ptr  <= '0;
            rd_ptr      <= '0;
            frame_count <= '0;
            drop_pulse  <= 1'b0;
            dout        <= '0;
            sof_out     <= 1'b0;
            eof_out     <= 1'b0;
        end else begin
            state      <= next_state;
            drop_pulse <= do_drop;

            if (do_write) begin
                wr_ptr <= base_ptr + ptr_t'(1);
            end else if (reject) begin
                wr_ptr <= commit_ptr;
            end

            if (do_commit) begin
                commit_ptr <= base_ptr + ptr_t'(1);
            end

            if (rd_fire) begin
                rd_ptr  <= rd_ptr + ptr_t'(1);
                dout    <= rd_word.data;
                sof_out <= rd_word.sof;
                eof_out <= rd_word.eof;
            end

            case ({do_commit, rd_fire && rd_word.eof})
                2'b10:   frame_count <= frame_count + ptr_t'(1);
                2'b01:   frame_count <= frame_count - ptr_t'(1);
                default: frame_count <= frame_count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; pointers alone define which
    // entries are valid, so clearing it would only cost logic.
    always_ff @(posedge clock) begin
        if (do_write) begin
            mem[base_ptr[AW-1:0]] <= '{sof: bus.sof_in, eof: bus.eof_in, data: bus.din};
        end
    end

    // Flags are forced to their idle values while reset is held.
    assign bus.empty       = reset || (rd_ptr == commit_ptr);
    assign bus.full        = !reset && (occupancy == ptr_t'(DEPTH));
    assign bus.almost_full = !reset && (occupancy >= ptr_t'(AFULL_THRESH));
    assign bus.frame_count = frame_count;
    assign bus.drop_pulse  = drop_pulse;
    assign bus.dout        = dout;
    assign bus.sof_out     = sof_out;
    assign bus.eof_out     = eof_out;
endmodule

// File: doc/frame_fifo.md
FRAME_FIFO -- requirements
Module: frame_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 32, payload width in bits.
REQ-002 Parameter DEPTH, default 256, word capacity; SHALL be a power of two, at least 4.
REQ-003 Parameter AFULL_THRESH, default DEPTH-16, occupancy at which almost_full asserts.
REQ-004 clock  input  1  single clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 wr_en  input  1  write strobe.
REQ-007 sof_in / eof_in / err_in  input  1 each  start-of-frame, end-of-frame, frame-error markers, qualified by wr_en.
REQ-008 din  input  DATA_WIDTH  write data.
REQ-009 full / almost_full  output  1 each  write-side occupancy flags.
REQ-010 rd_en  input  1  read strobe.
REQ-011 dout  output  DATA_WIDTH; sof_out / eof_out  output  1 each  read word and its markers.
REQ-012 empty  output  1  no committed word available to read.
REQ-013 frame_count  output  $clog2(DEPTH)+1  committed frames not yet fully read.
REQ-014 drop_pulse  output  1  one-cycle pulse per discarded frame.

Function
REQ-015 Storage SHALL hold {sof, eof, data} per word; single-word frames (sof_in=eof_in=1) are legal.
REQ-016 Write FSM states SHALL be IDLE, IN_FRAME, DROP.
REQ-017 IDLE: wr_en with sof_in SHALL write the word and go to IN_FRAME (commit immediately if eof_in=1, err_in=0); wr_en without sof_in SHALL be ignored.
REQ-018 IN_FRAME: each wr_en SHALL write at speculative pointer wr_ptr; eof_in=1, err_in=0 SHALL set commit_ptr to wr_ptr+1 and return to IDLE.
REQ-019 err_in=1 on any accepted word SHALL rewind wr_ptr to commit_ptr, pulse drop_pulse, and go to IDLE if eof_in=1, else DROP.
REQ-020 wr_en while full in IN_FRAME SHALL be an overflow: rewind, drop_pulse, go to DROP (IDLE if eof_in=1).
REQ-021 sof_in in IN_FRAME (missing eof) SHALL rewind the partial frame, pulse drop_pulse, and start a new frame with the current word.
REQ-022 DROP SHALL discard all writes until an eof_in word (discarded), then go to IDLE; sof_in in DROP SHALL start a new frame as in IDLE.
REQ-023 Store-and-forward: reader SHALL see only committed words; empty = (rd_ptr == commit_ptr).
REQ-024 full = (wr_ptr - rd_ptr == DEPTH); almost_full = (wr_ptr - rd_ptr >= AFULL_THRESH); pointers SHALL be $clog2(DEPTH)+1 bits, wrapping modulo 2*DEPTH.
REQ-025 rd_en with empty=0 SHALL present the head word on dout/sof_out/eof_out at the next edge (1-cycle latency) and advance rd_ptr; rd_en with empty=1 SHALL be ignored, outputs held.
REQ-026 frame_count SHALL increment on commit, decrement on read of an eof word; both in one cycle leaves it unchanged.
REQ-027 Simultaneous read and write in one cycle SHALL both proceed, including at full (read frees no space for that same write; write then overflows).
REQ-028 A commit and a drop SHALL never occur for the same word.

Reset
REQ-029 reset SHALL clear wr_ptr, commit_ptr, rd_ptr, frame_count to 0 and FSM to IDLE.
REQ-030 During reset: dout=0, sof_out=0, eof_out=0, empty=1, full=0, almost_full=0, drop_pulse=0; storage contents need not clear.
REQ-031 reset mid-frame SHALL discard the partial frame without drop_pulse.

Verification
REQ-032 Write 4-word frame A0..A3 (sof on A0, eof on A3), then read 4 -> empty stays 1 until cycle after A3 write; reads return A0..A3, sof_out on A0, eof_out on A3; frame_count 1->0.
REQ-033 Write 3 words, err_in on third with eof -> drop_pulse one cycle, empty remains 1, frame_count 0, wr_ptr back to 0.
REQ-034 DEPTH=4: 6-word frame -> fifth write overflows, drop_pulse, remaining word plus eof discarded; a following 2-word frame commits and reads correctly.
REQ-035 Frame B words 0-1 then sof on new word C0, C1 eof -> one drop_pulse, only C0,C1 readable, frame_count 1.
REQ-036 Continuous single-word frames with simultaneous rd_en each cycle for 2*DEPTH+3 cycles -> pointer wrap, no data loss, frame_count never exceeds 1.
REQ-037 reset asserted mid-frame after 2 committed frames -> empty=1, frame_count=0, next frame behaves as after power-up.
